// File: rtl/prog_loader.sv
// Program loader: accepts a framed byte image, writes 14-bit instruction
// words sequentially into program memory, and releases the CPU from reset
// only after the whole image has been written and its checksum matches.
module prog_loader #(
    parameter int         ADDR_W    = 11,
    parameter int         DATA_W    = 14,
    parameter int         MAX_WORDS = 2048,
    parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                HI_W     = DATA_W - 8;
    // Bits of the high byte that lie above the instruction word and must be zero
    localparam logic [7:0]        HI_MASK  = 8'hFF << HI_W;
    localparam logic [16:0]       MAX_N    = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_CNT_HI,
        S_CNT_LO,
        S_W_HI,
        S_W_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [HI_W-1:0]   hi_q, hi_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        sum_q, sum_d;
    logic [15:0]       n_full;

    assign n_full     = {cnt_hi_q, rx_data};
    assign prog_addr  = addr_q;
    assign prog_wdata = {hi_q, lo_q};

    // State and datapath registers; reset leaves the CPU held and the loader idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_hi_q   <= '0;
            n_q        <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_hi_q   <= cnt_hi_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            sum_q      <= sum_d;
        end
    end

    // Frame parser: next state, datapath updates and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        sum_d      = sum_q;
        rx_ready   = 1'b0;
        prog_we    = 1'b0;
        cpu_reset  = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HDR;
            end
            S_HDR: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid && rx_data == HDR_BYTE) state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    cnt_hi_d = rx_data;
                    state_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (n_full == 16'd0 || {1'b0, n_full} > MAX_N) begin
                        state_d = S_ERR;
                    end else begin
                        n_d        = n_full;
                        word_cnt_d = '0;
                        addr_d     = '0;
                        sum_d      = '0;
                        state_d    = S_W_HI;
                    end
                end
            end
            S_W_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if ((rx_data & HI_MASK) != 8'd0) begin
                        state_d = S_ERR;
                    end else begin
                        hi_d    = rx_data[HI_W-1:0];
                        sum_d   = sum_q + rx_data;
                        state_d = S_W_LO;
                    end
                end
            end
            S_W_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    lo_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy       = 1'b1;
                prog_we    = 1'b1;
                addr_d     = addr_q + ADDR_ONE;
                word_cnt_d = word_cnt_q + 16'd1;
                if (word_cnt_q + 16'd1 == n_q) state_d = S_CHK;
                else                           state_d = S_W_HI;
            end
            S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (rx_data == sum_q) state_d = S_DONE;
                    else                  state_d = S_ERR;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) state_d = S_HDR;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_d = S_HDR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a frame-level reference model predicts
// the memory writes and final outcome, a monitor compares them as they appear.
module tb_prog_loader;

    typedef logic [7:0] byteQ_t[$];
    typedef struct {
        logic [10:0] addr;
        logic [13:0] data;
    } writeT;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        prog_we;
    logic [10:0] prog_addr;
    logic [13:0] prog_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    int          checks   = 0;
    int          failures = 0;
    writeT       wq[$];
    logic [1:0]  oq[$];
    logic        prevFin  = 1'b0;

    prog_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each write strobe and each load outcome against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            prevFin <= 1'b0;
        end else begin
            if (prog_we) begin
                if (wq.size() == 0) begin
                    checkOutput("unexpected_write", 32'(prog_we), 32'(0));
                end else begin
                    writeT e;
                    e = wq.pop_front();
                    checkOutput("write_addr", 32'(prog_addr), 32'(e.addr));
                    checkOutput("write_data", 32'(prog_wdata), 32'(e.data));
                end
            end
            if ((done || err) && !prevFin) begin
                if (oq.size() == 0) begin
                    checkOutput("unexpected_outcome", 32'({done, err}), 32'(0));
                end else begin
                    logic [1:0] o;
                    o = oq.pop_front();
                    checkOutput("outcome_done", 32'(done), 32'(o[1]));
                    checkOutput("outcome_err", 32'(err), 32'(o[0]));
                    checkOutput("outcome_cpu_reset", 32'(cpu_reset), 32'(!o[1]));
                    checkOutput("outcome_busy", 32'(busy), 32'(0));
                end
            end
            prevFin <= done || err;
        end
    end

    // Reference model: parse the frame as a whole and predict writes and outcome
    task automatic modelFrame(input byteQ_t b, output int consumed, output int outcome);
        int         i;
        int         n;
        logic [7:0] sum;
        logic [7:0] hi;
        logic [7:0] lo;
        writeT      e;
        i       = 0;
        outcome = 0;
        while (i < b.size() && b[i] != 8'hA5) i++;
        i++;
        n = {b[i], b[i+1]};
        i += 2;
        if (n == 0 || n > 2048) begin
            consumed = i;
            outcome  = 2;
            oq.push_back(2'b01);
            return;
        end
        sum = 8'd0;
        for (int w = 0; w < n; w++) begin
            hi = b[i];
            i++;
            if (hi > 8'h3F) begin
                consumed = i;
                outcome  = 2;
                oq.push_back(2'b01);
                return;
            end
            lo = b[i];
            i++;
            sum    = sum + hi + lo;
            e.addr = w[10:0];
            e.data = {hi[5:0], lo};
            wq.push_back(e);
        end
        outcome  = (b[i] == sum) ? 1 : 2;
        consumed = i + 1;
        oq.push_back((outcome == 1) ? 2'b10 : 2'b01);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy", 32'(busy), 32'(1));
        checkOutput("start_done", 32'(done), 32'(0));
        checkOutput("start_err", 32'(err), 32'(0));
        checkOutput("start_cpu_reset", 32'(cpu_reset), 32'(1));
        checkOutput("start_rx_ready", 32'(rx_ready), 32'(1));
    endtask

    // Idle cycles with junk on the bus and occasional start pulses that must be ignored
    task automatic gap(input int maxIdle);
        repeat ($urandom_range(0, maxIdle)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic sendByte(input logic [7:0] v);
        int cyc;
        rx_data  = v;
        rx_valid = 1'b1;
        cyc      = 0;
        while (!rx_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("rx_ready_wait", 32'(rx_ready), 32'(1));
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic applyStimulus(input byteQ_t b, input int maxIdle);
        int consumed;
        int outcome;
        int cyc;
        modelFrame(b, consumed, outcome);
        pulseStart();
        for (int k = 0; k < consumed; k++) begin
            gap(maxIdle);
            sendByte(b[k]);
        end
        cyc = 0;
        while (!(done || err) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("outcome_seen", 32'(done || err), 32'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rx_ready"}, 32'(rx_ready), 32'(0));
        checkOutput({tag, "_prog_we"}, 32'(prog_we), 32'(0));
        checkOutput({tag, "_prog_addr"}, 32'(prog_addr), 32'(0));
        checkOutput({tag, "_prog_wdata"}, 32'(prog_wdata), 32'(0));
        checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(1));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
        checkOutput({tag, "_done"}, 32'(done), 32'(0));
        checkOutput({tag, "_err"}, 32'(err), 32'(0));
    endtask

    task automatic buildRandom(output byteQ_t b);
        int         n;
        logic [7:0] sum;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] j;
        b = {};
        repeat ($urandom_range(0, 2)) begin
            j = 8'($urandom);
            if (j == 8'hA5) j = 8'h00;
            b.push_back(j);
        end
        b.push_back(8'hA5);
        case ($urandom_range(0, 9))
            0:       n = 0;
            1:       n = $urandom_range(2049, 65535);
            default: n = $urandom_range(1, 6);
        endcase
        b.push_back(8'(n >> 8));
        b.push_back(8'(n));
        sum = 8'd0;
        for (int w = 0; w < ((n > 6) ? 6 : n); w++) begin
            hi = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
            lo = 8'($urandom);
            sum = sum + hi + lo;
            b.push_back(hi);
            b.push_back(lo);
        end
        b.push_back(($urandom_range(0, 4) == 0) ? sum + 8'd1 : sum);
    endtask

    // Main stimulus sequence
    initial begin
        byteQ_t b;
        writeT  e;
        reset    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_rx_ready", 32'(rx_ready), 32'(0));
        checkOutput("idle_cpu_reset", 32'(cpu_reset), 32'(1));

        // Good two-word frame
        b = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h76};
        applyStimulus(b, 0);
        // Same frame with a bad checksum
        b = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h77};
        applyStimulus(b, 0);
        // Leading junk must be discarded
        b = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h28, 8'h0A, 8'h32};
        applyStimulus(b, 1);
        // Illegal counts
        b = '{8'hA5, 8'h00, 8'h00};
        applyStimulus(b, 0);
        b = '{8'hA5, 8'h08, 8'h01};
        applyStimulus(b, 0);
        // Illegal high byte, then recovery with a good frame
        b = '{8'hA5, 8'h00, 8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(b, 0);
        b = '{8'hA5, 8'h00, 8'h02, 8'h30, 8'h05, 8'h3E, 8'h03, 8'h76};
        applyStimulus(b, 2);

        // Largest legal image
        begin
            logic [7:0] sum;
            logic [7:0] hi;
            logic [7:0] lo;
            b   = '{8'hA5, 8'h08, 8'h00};
            sum = 8'd0;
            for (int w = 0; w < 2048; w++) begin
                hi  = 8'($urandom_range(0, 63));
                lo  = 8'($urandom);
                sum = sum + hi + lo;
                b.push_back(hi);
                b.push_back(lo);
            end
            b.push_back(sum);
            applyStimulus(b, 0);
        end

        // Randomised frames with stalls and ignored start pulses
        for (int t = 0; t < 40; t++) begin
            buildRandom(b);
            applyStimulus(b, 2);
        end

        // Stall in the middle of a word, then asynchronous reset during W_LO
        pulseStart();
        e.addr = 11'd0;
        e.data = 14'h1234;
        wq.push_back(e);
        b = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h05};
        for (int k = 0; k < b.size(); k++) sendByte(b[k]);
        rx_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("stall_busy", 32'(busy), 32'(1));
        #2 reset = 1'b0;
        #1 checkResetValues("async_rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("post_rst");
        checkOutput("wq_after_reset", 32'(wq.size()), 32'(0));

        // Loader must come back cleanly after the reset
        b = '{8'hA5, 8'h00, 8'h01, 8'h28, 8'h0A, 8'h32};
        applyStimulus(b, 1);

        checkOutput("write_queue_empty", 32'(wq.size()), 32'(0));
        checkOutput("outcome_queue_empty", 32'(oq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
